systolic_array_ctrl: RTL and testbench

Job sequencer for the 4x4 systolic array. It buffers one 4x4 A operand set and one 4x4 B operand set through a valid/ready load port, then clears the array. It streams the operands in the diagonal skew the array expects, waits for the pipeline to drain, and captures the array's 17-bit sum and carry into a held result with a valid/ready handshake. It sits between the host/DMA side and `systolic_array_4x4`, and drives that array's `a_in`, `b_in` and clear.

---
 rtl/systolic_array_ctrl_if.sv | 33 +++
 rtl/systolic_array_ctrl.sv | 169 ++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl_if
// Brief    : Load, array and result bundle for the systolic array job sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_array_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        abort;
  logic [31:0] arr_a;
  logic [31:0] arr_b;
  logic        arr_clr;
  logic [16:0] arr_sum;
  logic        arr_cout;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_sum;
  logic        res_cout;
  logic [15:0] perf_cycles;

  modport slave (
    input  ld_valid, ld_data, abort, arr_sum, arr_cout, res_ready,
    output ld_ready, arr_a, arr_b, arr_clr, res_valid, res_sum, res_cout, perf_cycles
  );

  modport master (
    output ld_valid, ld_data, abort, arr_sum, arr_cout, res_ready,
    input  ld_ready, arr_a, arr_b, arr_clr, res_valid, res_sum, res_cout, perf_cycles
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl
// Brief    : Buffers A/B operands, streams them skewed into the 4x4 systolic
//            array, drains and captures the result. Optional busy-cycle
//            counter enabled by SA_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  systolic_array_ctrl_if.slave bus_io
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [3:0] C_FEED_LAST  = 4'd6;
  localparam logic [3:0] C_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [3:0]       step_q, step_d;
  logic [3:0][31:0] a_q, a_d, b_q, b_d;
  logic [31:0]      arr_a_q, arr_a_d, arr_b_q, arr_b_d;
  logic             arr_clr_q, arr_clr_d;
  logic             res_valid_q, res_valid_d;
  logic [16:0]      res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             ld_ready, accept, abort_act, capture;
  logic [3:0][7:0]  lane_a, lane_b;

  assign ld_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept    = bus_io.ld_valid && ld_ready;
  assign abort_act = bus_io.abort && (state_q != S_IDLE);
  assign capture   = (state_q == S_DRAIN) && (step_q == C_DRAIN_LAST) && !abort_act;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    step_d      = '0;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    if (accept) begin
      wcnt_d = wcnt_q + 3'd1;
      if (wcnt_q[2]) b_d[wcnt_q[1:0]] = bus_io.ld_data;
      else           a_d[wcnt_q[1:0]] = bus_io.ld_data;
    end
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  if (accept && (wcnt_q == 3'd7)) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (step_q == C_FEED_LAST) state_d = S_DRAIN;
        else                       step_d  = step_q + 4'd1;
      end
      S_DRAIN: begin
        if (step_q == C_DRAIN_LAST) state_d = S_DONE;
        else                        step_d  = step_q + 4'd1;
      end
      S_DONE: begin
        if (bus_io.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      res_valid_d = 1'b1;
      res_sum_d   = bus_io.arr_sum;
      res_cout_d  = bus_io.arr_cout;
    end
    // Abort beats any same-cycle result handshake; operand buffers are kept.
    if (abort_act) begin
      state_d     = S_IDLE;
      wcnt_d      = '0;
      step_d      = '0;
      res_valid_d = 1'b0;
    end
  end

  // Skew lanes are computed from next state so the registered outputs line up with FEED step t.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [3:0] k;
    assign k          = step_d - 4'(gi);
    assign lane_a[gi] = ((state_d == S_FEED) && (k <= 4'd3)) ? a_q[gi][{k[1:0], 3'b000} +: 8] : 8'h00;
    assign lane_b[gi] = ((state_d == S_FEED) && (k <= 4'd3)) ? b_q[gi][{k[1:0], 3'b000} +: 8] : 8'h00;
  end

  assign arr_a_d   = lane_a;
  assign arr_b_d   = lane_b;
  assign arr_clr_d = (state_d == S_CLEAR) || abort_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      arr_a_q     <= '0;
      arr_b_q     <= '0;
      arr_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      arr_a_q     <= arr_a_d;
      arr_b_q     <= arr_b_d;
      arr_clr_q   <= arr_clr_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end

  assign bus_io.ld_ready  = ld_ready;
  assign bus_io.arr_a     = arr_a_q;
  assign bus_io.arr_b     = arr_b_q;
  assign bus_io.arr_clr   = arr_clr_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_sum   = res_sum_q;
  assign bus_io.res_cout  = res_cout_q;

`ifdef SA_CTRL_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d, perf_cycles_q, perf_cycles_d, perf_inc;

  assign perf_inc = (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;

  always_comb begin
    perf_cnt_d    = '0;
    perf_cycles_d = perf_cycles_q;
    if (!abort_act && ((state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN)))
      perf_cnt_d = perf_inc;
    if (capture) perf_cycles_d = perf_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign bus_io.perf_cycles = perf_cycles_q;
`else
  assign bus_io.perf_cycles = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_ctrl
// Brief    : Self-checking bench for systolic_array_ctrl (job table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int LAT          = 8 + DRAIN_CYCLES;
`ifdef SA_CTRL_PERF_EN
  localparam logic [31:0] EXP_PERF = 32'(1 + 7 + DRAIN_CYCLES);
`else
  localparam logic [31:0] EXP_PERF = 32'd0;
`endif

  localparam logic [6:0][31:0] PAT  = {32'h34000000, 32'h33240000, 32'h32231400, 32'h31221304,
                                       32'h00211203, 32'h00001102, 32'h00000001};
  localparam logic [6:0][31:0] ONES = {32'h01000000, 32'h01010000, 32'h01010100, 32'h01010101,
                                       32'h00010101, 32'h00000101, 32'h00000001};
  localparam logic [6:0][31:0] FULL = {32'hFF000000, 32'hFFFF0000, 32'hFFFFFF00, 32'hFFFFFFFF,
                                       32'h00FFFFFF, 32'h0000FFFF, 32'h000000FF};
  localparam logic [3:0][31:0] PAT_W  = {32'h34333231, 32'h24232221, 32'h14131211, 32'h04030201};
  localparam logic [3:0][31:0] ONES_W = {4{32'h01010101}};

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [16:0]      sum;
    logic             cout;
    logic [6:0][31:0] exp_a;
    logic [6:0][31:0] exp_b;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_ctrl_if sa_if ();

  systolic_array_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (sa_if)
  );

  job_t        jobs [3];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic [17:0] q_res [$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ld_ready"},  32'(sa_if.ld_ready),    32'd1);
    check({tag, "_arr_a"},     sa_if.arr_a,            32'd0);
    check({tag, "_arr_b"},     sa_if.arr_b,            32'd0);
    check({tag, "_arr_clr"},   32'(sa_if.arr_clr),     32'd0);
    check({tag, "_res_valid"}, 32'(sa_if.res_valid),   32'd0);
    check({tag, "_res_sum"},   32'(sa_if.res_sum),     32'd0);
    check({tag, "_res_cout"},  32'(sa_if.res_cout),    32'd0);
    check({tag, "_perf"},      32'(sa_if.perf_cycles), 32'd0);
  endtask

  task automatic load_job(input int j, input bit abort_w0);
    sa_if.arr_sum  = jobs[j].sum;
    sa_if.arr_cout = jobs[j].cout;
    for (int w = 0; w < 8; w++) begin
      sa_if.ld_valid = 1'b1;
      sa_if.ld_data  = (w < 4) ? jobs[j].a[w] : jobs[j].b[w-4];
      sa_if.abort    = abort_w0 && (w == 0);
      check("ld_ready_load", 32'(sa_if.ld_ready), 32'd1);
      @(posedge clk); #1;
    end
    sa_if.ld_valid = 1'b0;
    sa_if.abort    = 1'b0;
    for (int t = 0; t < 7; t++) begin
      q_a.push_back(jobs[j].exp_a[t]);
      q_b.push_back(jobs[j].exp_b[t]);
    end
    q_res.push_back({jobs[j].cout, jobs[j].sum});
  endtask

  task automatic run_job(input int j, input int abort_t, input bit abort_w0, input bit abort_done);
    int          lat;
    bit          rose;
    logic [31:0] ea, eb;
    logic [17:0] er;
    load_job(j, abort_w0);
    check("clr_in_clear", 32'(sa_if.arr_clr), 32'd1);
    check("arr_a_in_clear", sa_if.arr_a, 32'd0);
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      check($sformatf("arr_a_t%0d", t), sa_if.arr_a, ea);
      check($sformatf("arr_b_t%0d", t), sa_if.arr_b, eb);
      check("clr_in_feed", 32'(sa_if.arr_clr), 32'd0);
      if (t == abort_t) begin
        sa_if.abort = 1'b1;
        @(posedge clk); #1;
        sa_if.abort = 1'b0;
        check("abort_clr",       32'(sa_if.arr_clr),   32'd1);
        check("abort_arr_a",     sa_if.arr_a,          32'd0);
        check("abort_arr_b",     sa_if.arr_b,          32'd0);
        check("abort_ld_ready",  32'(sa_if.ld_ready),  32'd1);
        check("abort_res_valid", 32'(sa_if.res_valid), 32'd0);
        @(posedge clk); #1;
        check("abort_clr_drop", 32'(sa_if.arr_clr), 32'd0);
        rose = 1'b0;
        repeat (15) begin
          @(posedge clk); #1;
          if (sa_if.res_valid === 1'b1) rose = 1'b1;
        end
        check("res_after_abort", 32'(rose), 32'd0);
        q_a.delete();
        q_b.delete();
        q_res.delete();
        return;
      end
    end
    lat = 7;
    while (sa_if.res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_latency", 32'(lat), 32'(LAT));
    er = q_res.pop_front();
    check("res_sum",  32'(sa_if.res_sum),     32'(er[16:0]));
    check("res_cout", 32'(sa_if.res_cout),    32'(er[17]));
    check("perf",     32'(sa_if.perf_cycles), EXP_PERF);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid",    32'(sa_if.res_valid), 32'd1);
      check("hold_sum",      32'(sa_if.res_sum),   32'(er[16:0]));
      check("hold_cout",     32'(sa_if.res_cout),  32'(er[17]));
      check("hold_ld_ready", 32'(sa_if.ld_ready),  32'd0);
    end
    sa_if.res_ready = 1'b1;
    sa_if.abort     = abort_done;
    @(posedge clk); #1;
    sa_if.res_ready = 1'b0;
    sa_if.abort     = 1'b0;
    check("done_valid_clr", 32'(sa_if.res_valid), 32'd0);
    check("done_ld_ready",  32'(sa_if.ld_ready),  32'd1);
    check("done_arr_clr",   32'(sa_if.arr_clr),   32'(abort_done));
  endtask

  initial begin
    jobs[0] = '{a: PAT_W,  b: ONES_W, sum: 17'h1ABCD, cout: 1'b1, exp_a: PAT,  exp_b: ONES};
    jobs[1] = '{a: ONES_W, b: PAT_W,  sum: 17'h00001, cout: 1'b0, exp_a: ONES, exp_b: PAT};
    jobs[2] = '{a: {4{32'hFFFFFFFF}}, b: '0, sum: 17'h10000, cout: 1'b0, exp_a: FULL, exp_b: '0};

    sa_if.ld_valid  = 1'b0;
    sa_if.ld_data   = '0;
    sa_if.abort     = 1'b0;
    sa_if.arr_sum   = '0;
    sa_if.arr_cout  = 1'b0;
    sa_if.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ld_ready", 32'(sa_if.ld_ready), 32'd1);

    for (int j = 0; j < 3; j++) run_job(j, -1, 1'b0, 1'b0);

    run_job(1, 3, 1'b0, 1'b0);
    run_job(0, -1, 1'b0, 1'b0);

    // Abort mid-LOAD: the following job must restart at word 0.
    for (int w = 0; w < 3; w++) begin
      sa_if.ld_valid = 1'b1;
      sa_if.ld_data  = 32'hDEAD0000 + 32'(w);
      @(posedge clk); #1;
    end
    sa_if.ld_valid = 1'b0;
    sa_if.abort    = 1'b1;
    @(posedge clk); #1;
    sa_if.abort = 1'b0;
    check("load_abort_clr",      32'(sa_if.arr_clr),  32'd1);
    check("load_abort_ld_ready", 32'(sa_if.ld_ready), 32'd1);
    run_job(1, -1, 1'b0, 1'b0);

    run_job(2, -1, 1'b1, 1'b0);
    run_job(0, -1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of FEED.
    load_job(1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid_feed");
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_feed_ld_ready", 32'(sa_if.ld_ready), 32'd1);
    q_a.delete();
    q_b.delete();
    q_res.delete();
    run_job(2, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
